// File: rtl/mcse_bus_arbiter_if.sv
// MCSE requester / BTU port bundle for the bus arbiter.
// master = arbiter side, slave = requesters plus BTU.
interface mcse_bus_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int AW    = 32,
  parameter int PW    = 128
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*PW-1:0] req_write;
  logic [N_REQ-1:0]    req_RW;
  logic [N_REQ-1:0]    req_done;
  logic                req_err;
  logic [PW-1:0]       req_rdData;
  logic [IW-1:0]       gnt_id;

  logic                bootControl_bus_go;
  logic [AW-1:0]       bootControl_bus_addr;
  logic [PW-1:0]       bootControl_bus_write;
  logic                bootControl_bus_RW;
  logic                bootControl_bus_done;
  logic [PW-1:0]       bootControl_bus_rdData;

  modport master (
    input  req_valid, req_lock, req_addr,
    input  req_write, req_RW,
    output req_done, req_err, req_rdData,
    output gnt_id,
    output bootControl_bus_go,
    output bootControl_bus_addr,
    output bootControl_bus_write,
    output bootControl_bus_RW,
    input  bootControl_bus_done,
    input  bootControl_bus_rdData
  );

  modport slave (
    output req_valid, req_lock, req_addr,
    output req_write, req_RW,
    input  req_done, req_err, req_rdData,
    input  gnt_id,
    input  bootControl_bus_go,
    input  bootControl_bus_addr,
    input  bootControl_bus_write,
    input  bootControl_bus_RW,
    output bootControl_bus_done,
    output bootControl_bus_rdData
  );
endinterface

// File: rtl/mcse_bus_arbiter.sv
// Round-robin arbiter sharing the single BTU port among MCSE requesters.
// One transaction at a time: go pulse, wait for done or timeout, respond.
module mcse_bus_arbiter #(
  parameter int N_REQ              = 2,
  parameter int pAHB_ADDR_WIDTH    = 32,
  parameter int pPAYLOAD_SIZE_BITS = 128,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input logic clk,
  input logic rst_n,
  mcse_bus_arbiter_if.master bus
);
  localparam int AW = pAHB_ADDR_WIDTH;
  localparam int PW = pPAYLOAD_SIZE_BITS;
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST    = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t         state;
  logic [IW-1:0]  rr;
  logic [IW-1:0]  gnt;
  logic [IW-1:0]  win;
  logic [IW-1:0]  pick;
  logic [CW-1:0]  cnt;
  logic           go;
  logic [N_REQ-1:0] done;
  logic           err;
  logic [PW-1:0]  rdata;
  logic [AW-1:0]  addr;
  logic [PW-1:0]  wdata;
  logic           rw;
  logic           relock;
  logic [AW-1:0]  sel_addr;
  logic [PW-1:0]  sel_write;
  logic           sel_rw;

  // Descending scan so the lowest offset from rr wins.
  always_comb begin
    int idx;
    logic [IW-1:0] cand;
    idx  = 0;
    cand = '0;
    win  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IW'(idx);
      if (bus.req_valid[cand]) win = cand;
    end
  end

  assign relock = bus.req_lock[gnt] & bus.req_valid[gnt];
  assign pick   = (state == RESP) ? gnt : win;

  always_comb begin
    sel_addr  = '0;
    sel_write = '0;
    sel_rw    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_write = bus.req_write[i*PW +: PW];
        sel_rw    = bus.req_RW[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr    <= '0;
      gnt   <= '0;
      cnt   <= '0;
      go    <= 1'b0;
      done  <= '0;
      err   <= 1'b0;
      rdata <= '0;
      addr  <= '0;
      wdata <= '0;
      rw    <= 1'b0;
    end else begin
      go   <= 1'b0;
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            gnt   <= win;
            addr  <= sel_addr;
            wdata <= sel_write;
            rw    <= sel_rw;
            go    <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.bootControl_bus_done) begin
            rdata     <= bus.bootControl_bus_rdData;
            err       <= 1'b0;
            done[gnt] <= 1'b1;
            state     <= RESP;
          end else if (cnt == CNT_MAX) begin
            rdata     <= '0;
            err       <= 1'b1;
            done[gnt] <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (relock) begin
            addr  <= sel_addr;
            wdata <= sel_write;
            rw    <= sel_rw;
            go    <= 1'b1;
            state <= ISSUE;
          end else begin
            rr    <= (gnt == LAST) ? '0 : gnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_done              = done;
  assign bus.req_err               = err;
  assign bus.req_rdData            = rdata;
  assign bus.gnt_id                = gnt;
  assign bus.bootControl_bus_go    = go;
  assign bus.bootControl_bus_addr  = addr;
  assign bus.bootControl_bus_write = wdata;
  assign bus.bootControl_bus_RW    = rw;
endmodule

// File: tb/tb_mcse_bus_arbiter.sv
// Self-checking bench for mcse_bus_arbiter: directed scenarios plus
// randomized traffic against a round-robin/lock/timeout reference model.
module tb_mcse_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int PW = 128;
  localparam int T  = 8;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcse_bus_arbiter_if #(.N_REQ(N), .AW(AW), .PW(PW)) bus ();

  mcse_bus_arbiter #(
    .N_REQ(N),
    .pAHB_ADDR_WIDTH(AW),
    .pPAYLOAD_SIZE_BITS(PW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic          m_v  [N];
  logic          m_l  [N];
  logic          m_rw [N];
  logic [AW-1:0] m_a  [N];
  logic [PW-1:0] m_w  [N];

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign bus.req_valid[i]           = m_v[i];
    assign bus.req_lock[i]            = m_l[i];
    assign bus.req_RW[i]              = m_rw[i];
    assign bus.req_addr[i*AW +: AW]   = m_a[i];
    assign bus.req_write[i*PW +: PW]  = m_w[i];
  end

  int n_chk;
  int n_fail;
  int cyc;
  int last_resp;
  int ptr;
  int forced;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [PW-1:0] rand_pw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < N; k++)
      if (m_v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_l[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input bit l, input bit rw);
    m_v[i]  = 1'b1;
    m_l[i]  = l;
    m_rw[i] = rw;
    m_a[i]  = $urandom;
    m_w[i]  = rand_pw();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ptr = 0;
    forced = -1;
    last_resp = -100;
  endtask

  // One granted transaction: expected grant from the model, BTU answers
  // after dly WAIT cycles (0 = never), optional field update during WAIT.
  task automatic run_txn(input int dly, input logic [PW-1:0] data,
                         input bit upd, input logic [AW-1:0] na,
                         input logic [PW-1:0] nw, input bit nrw,
                         input bit nl, input int gap);
    int eid, n, er;
    logic [AW+PW:0] lat;
    logic [PW-1:0] erd;
    logic [N-1:0] ed;
    eid = (forced >= 0) ? forced : rr_pick();
    n = 0;
    while (bus.bootControl_bus_go !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (bus.bootControl_bus_go !== 1'b1) begin
      n_fail++;
      $display("FAIL go_wait: go=%b after %0d cycles, want 1",
               bus.bootControl_bus_go, n);
      return;
    end
    if (gap > 0) begin
      n_chk++;
      if (cyc - last_resp != gap) begin
        n_fail++;
        $display("FAIL go_gap: got %0d cycles, want %0d",
                 cyc - last_resp, gap);
      end
    end
    n_chk++;
    if (bus.gnt_id !== IW'(eid)) begin
      n_fail++;
      $display("FAIL gnt_id: got %0d, want %0d", bus.gnt_id, eid);
    end
    lat = {m_a[eid], m_w[eid], m_rw[eid]};
    n_chk++;
    if ({bus.bootControl_bus_addr, bus.bootControl_bus_write,
         bus.bootControl_bus_RW} !== lat) begin
      n_fail++;
      $display("FAIL bus_fields: addr %h rw %b, want addr %h rw %b",
               bus.bootControl_bus_addr, bus.bootControl_bus_RW,
               m_a[eid], m_rw[eid]);
    end
    if (upd) begin
      m_a[eid]  = na;
      m_w[eid]  = nw;
      m_rw[eid] = nrw;
      m_l[eid]  = nl;
    end
    er  = (dly == 0) ? T + 1 : dly + 1;
    erd = (dly == 0) ? '0 : data;
    ed  = '0;
    ed[eid] = 1'b1;
    for (int i = 1; i <= er; i++) begin
      tick();
      bus.bootControl_bus_done = 1'b0;
      n_chk++;
      if ({bus.bootControl_bus_addr, bus.bootControl_bus_write,
           bus.bootControl_bus_RW} !== lat) begin
        n_fail++;
        $display("FAIL bus_hold: addr %h, want %h at wait %0d",
                 bus.bootControl_bus_addr, lat[AW+PW:PW+1], i);
      end
      if (i < er) begin
        n_chk++;
        if ({bus.req_done, bus.bootControl_bus_go} !== '0) begin
          n_fail++;
          $display("FAIL early: done %b go %b at wait %0d, want 0",
                   bus.req_done, bus.bootControl_bus_go, i);
        end
      end
      if (i == dly) begin
        bus.bootControl_bus_done   = 1'b1;
        bus.bootControl_bus_rdData = data;
      end else begin
        bus.bootControl_bus_rdData = rand_pw();
      end
    end
    n_chk++;
    if (bus.req_done !== ed) begin
      n_fail++;
      $display("FAIL req_done: got %b, want %b", bus.req_done, ed);
    end
    n_chk++;
    if ({bus.req_err, bus.req_rdData} !== {dly == 0, erd}) begin
      n_fail++;
      $display("FAIL resp: err %b data %h, want err %b data %h",
               bus.req_err, bus.req_rdData, dly == 0, erd);
    end
    if (m_l[eid] && m_v[eid]) begin
      forced = eid;
    end else begin
      forced = -1;
      ptr = (eid + 1) % N;
    end
    last_resp = cyc;
    tick();
    n_chk++;
    if (bus.req_done !== '0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b, want 0", bus.req_done);
    end
  endtask

  task automatic test_reset();
    tick();
    n_chk++;
    if ({bus.req_done, bus.req_err, bus.gnt_id,
         bus.bootControl_bus_go} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: done %b err %b gnt %0d go %b, want 0",
               bus.req_done, bus.req_err, bus.gnt_id,
               bus.bootControl_bus_go);
    end
    n_chk++;
    if ({bus.req_rdData, bus.bootControl_bus_addr,
         bus.bootControl_bus_write, bus.bootControl_bus_RW} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rd %h addr %h, want 0",
               bus.req_rdData, bus.bootControl_bus_addr);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.bootControl_bus_go !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_go: got %b, want 0", bus.bootControl_bus_go);
      end
    end
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 1'b0);
    m_a[0] = 32'h40;
    last_resp = cyc;
    run_txn(5, 128'hDEAD, 1'b0, '0, '0, 1'b0, 1'b0, 1);
    clear_reqs();
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, 1'b0, 1'b0);
    set_req(1, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++)
      run_txn($urandom_range(1, 7), rand_pw(), 1'b0, '0, '0, 1'b0,
              1'b0, (j > 0) ? 2 : 0);
    clear_reqs();
  endtask

  task automatic test_lock_burst();
    tick();
    set_req(1, 1'b1, 1'b1);
    run_txn($urandom_range(1, 7), rand_pw(), 1'b1, $urandom, rand_pw(),
            1'b1, 1'b1, 0);
    set_req(0, 1'b0, 1'b0);
    run_txn($urandom_range(1, 7), rand_pw(), 1'b1, $urandom, rand_pw(),
            1'b1, 1'b1, 1);
    run_txn($urandom_range(1, 7), rand_pw(), 1'b1, $urandom, rand_pw(),
            1'b0, 1'b0, 1);
    run_txn($urandom_range(1, 7), rand_pw(), 1'b0, '0, '0, 1'b0, 1'b0, 2);
    run_txn($urandom_range(1, 7), rand_pw(), 1'b0, '0, '0, 1'b0, 1'b0, 2);
    clear_reqs();
  endtask

  task automatic test_timeout();
    tick();
    set_req(0, 1'b0, 1'b0);
    run_txn(0, rand_pw(), 1'b0, '0, '0, 1'b0, 1'b0, 0);
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.bootControl_bus_go !== 1'b0) begin
        n_fail++;
        $display("FAIL post_timeout_go: got %b, want 0",
                 bus.bootControl_bus_go);
      end
    end
    set_req(1, 1'b0, 1'b1);
    run_txn(T, rand_pw(), 1'b0, '0, '0, 1'b0, 1'b0, 0);
    clear_reqs();
  endtask

  task automatic test_spurious();
    tick();
    bus.bootControl_bus_done = 1'b1;
    tick();
    bus.bootControl_bus_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({bus.req_done, bus.bootControl_bus_go} !== '0) begin
        n_fail++;
        $display("FAIL spurious: done %b go %b, want 0",
                 bus.req_done, bus.bootControl_bus_go);
      end
    end
    set_req(0, 1'b0, 1'b1);
    run_txn(4, rand_pw(), 1'b1, $urandom, rand_pw(), 1'b0, 1'b0, 0);
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    int n;
    tick();
    set_req(1, 1'b0, 1'b1);
    n = 0;
    while (bus.bootControl_bus_go !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (bus.gnt_id !== 1'b1 || bus.bootControl_bus_go !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_gnt: gnt %0d go %b, want 1 1",
               bus.gnt_id, bus.bootControl_bus_go);
    end
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.req_done, bus.req_err, bus.req_rdData, bus.gnt_id,
         bus.bootControl_bus_go, bus.bootControl_bus_addr,
         bus.bootControl_bus_write, bus.bootControl_bus_RW} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: gnt %0d addr %h, want all 0",
               bus.gnt_id, bus.bootControl_bus_addr);
    end
    set_req(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.req_done !== '0) begin
        n_fail++;
        $display("FAIL reset_done: got %b, want 0", bus.req_done);
      end
    end
    rst_n = 1'b1;
    ptr = 0;
    forced = -1;
    run_txn($urandom_range(1, 7), rand_pw(), 1'b0, '0, '0, 1'b0, 1'b0, 0);
    clear_reqs();
  endtask

  task automatic test_random();
    int gap;
    bit any;
    tick();
    for (int it = 0; it < 30; it++) begin
      gap = (it == 0) ? 0 : ((forced >= 0) ? 1 : 2);
      any = (forced >= 0);
      for (int i = 0; i < N; i++) begin
        if (i != forced) begin
          if ($urandom_range(0, 1) == 1) begin
            set_req(i, $urandom_range(0, 3) == 0, 1'($urandom));
            any = 1'b1;
          end else begin
            m_v[i] = 1'b0;
          end
        end
      end
      if (!any) set_req($urandom_range(0, N - 1), 1'b0, 1'($urandom));
      run_txn($urandom_range(0, T), rand_pw(), 1'($urandom), $urandom,
              rand_pw(), 1'($urandom), $urandom_range(0, 2) == 0, gap);
    end
    clear_reqs();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    ptr = 0;
    forced = -1;
    last_resp = -100;
    bus.bootControl_bus_done = 1'b0;
    bus.bootControl_bus_rdData = '0;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_l[i] = 1'b0;
      m_rw[i] = 1'b0;
      m_a[i] = '0;
      m_w[i] = '0;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_timeout();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
